parity_gen_chk: RTL and testbench

//  Parametrised UART parity engine: generates the TX parity bit and checks RX parity serially.

---
 rtl/parity_gen_chk_pkg.sv | 20 ++
 rtl/parity_gen_chk_if.sv | 29 ++
 rtl/parity_gen_chk_rx_chk.sv | 61 ++++++
 rtl/parity_gen_chk.sv | 58 +++++
 tb/tb_parity_gen_chk.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/parity_gen_chk_pkg.sv
// parity_gen_chk_pkg: parity mode codes, RX state encoding and the shared parity rule.
package parity_gen_chk_pkg;
    typedef logic [2:0] par_mode_t;
    localparam par_mode_t PAR_NONE  = 3'd0;
    localparam par_mode_t PAR_EVEN  = 3'd1;
    localparam par_mode_t PAR_ODD   = 3'd2;
    localparam par_mode_t PAR_MARK  = 3'd3;
    localparam par_mode_t PAR_SPACE = 3'd4;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } rx_state_e;
    // Codes 5..7 fall through to the even rule.
    function automatic logic exp_parity(input par_mode_t mode, input logic xor_acc);
        return (mode == PAR_NONE || mode == PAR_SPACE) ? 1'b0 :
               (mode == PAR_MARK) ? 1'b1 :
               (mode == PAR_ODD)  ? ~xor_acc : xor_acc;
    endfunction
endpackage

// File: rtl/parity_gen_chk_if.sv
// parity_gen_chk_if: TX load, RX bit stream and error-reporting signals of the parity engine.
interface parity_gen_chk_if
    import parity_gen_chk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    par_mode_t            PAR_MODE;
    logic                 tx_load;
    logic [WIDTH-1:0]     P_DATA;
    logic                 parity_bit;
    logic                 par_req;
    logic                 rx_start;
    logic                 rx_bit_vld;
    logic                 rx_bit;
    logic                 rx_done;
    logic                 rx_par_err;
    logic                 err_sticky;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;
    modport master (
        output PAR_MODE, tx_load, P_DATA, rx_start, rx_bit_vld, rx_bit, err_clr,
        input  parity_bit, par_req, rx_done, rx_par_err, err_sticky, err_cnt
    );
    modport slave (
        input  PAR_MODE, tx_load, P_DATA, rx_start, rx_bit_vld, rx_bit, err_clr,
        output parity_bit, par_req, rx_done, rx_par_err, err_sticky, err_cnt
    );
endinterface

// File: rtl/parity_gen_chk_rx_chk.sv
// parity_rx_chk: serial RX parity checker; accumulates data bits, then compares the parity bit.
module parity_rx_chk
    import parity_gen_chk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  par_mode_t par_mode_i,
    input  logic      rx_start_i,
    input  logic      rx_bit_vld_i,
    input  logic      rx_bit_i,
    output logic      rx_done_o,
    output logic      rx_par_err_o,
    output logic      mism_o
);
    localparam int CW = $clog2(WIDTH + 1);
    rx_state_e   state_q;
    par_mode_t   mode_q;
    logic        acc_q;
    logic [CW-1:0] cnt_q;
    logic        rx_done_q;
    logic        rx_par_err_q;
    logic        last_bit;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // Combinational so the error counter updates on the same edge that registers rx_done.
    assign mism_o = (state_q == ST_PARITY) && rx_bit_vld_i && !rx_start_i &&
                    (rx_bit_i != exp_parity(mode_q, acc_q));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= PAR_NONE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            rx_done_q    <= 1'b0;
            rx_par_err_q <= 1'b0;
        end else begin
            rx_done_q    <= 1'b0;
            rx_par_err_q <= 1'b0;
            if (rx_start_i) begin
                state_q <= ST_DATA;
                mode_q  <= par_mode_i;
                acc_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (rx_bit_vld_i && state_q == ST_DATA) begin
                acc_q <= acc_q ^ rx_bit_i;
                cnt_q <= cnt_q + 1'b1;
                if (last_bit) begin
                    state_q   <= (mode_q == PAR_NONE) ? ST_IDLE : ST_PARITY;
                    rx_done_q <= (mode_q == PAR_NONE);
                end
            end else if (rx_bit_vld_i && state_q == ST_PARITY) begin
                state_q      <= ST_IDLE;
                rx_done_q    <= 1'b1;
                rx_par_err_q <= mism_o;
            end
        end
    end
    assign rx_done_o    = rx_done_q;
    assign rx_par_err_o = rx_par_err_q;
endmodule

// File: rtl/parity_gen_chk.sv
// parity_gen_chk: UART parity engine; TX parity generation, RX parity checking, error tracking.
module parity_gen_chk
    import parity_gen_chk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    parity_gen_chk_if.slave bus
);
    logic                 parity_bit_q;
    logic                 par_req_q;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_inc;
    logic                 mism;
    parity_rx_chk #(.WIDTH(WIDTH)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .par_mode_i   (bus.PAR_MODE),
        .rx_start_i   (bus.rx_start),
        .rx_bit_vld_i (bus.rx_bit_vld),
        .rx_bit_i     (bus.rx_bit),
        .rx_done_o    (bus.rx_done),
        .rx_par_err_o (bus.rx_par_err),
        .mism_o       (mism)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit_q <= 1'b0;
            par_req_q    <= 1'b0;
        end else if (bus.tx_load) begin
            parity_bit_q <= exp_parity(bus.PAR_MODE, ^bus.P_DATA);
            par_req_q    <= (bus.PAR_MODE != PAR_NONE);
        end
    end
    // A mismatch in the same cycle as err_clr restarts the count at one.
    always_comb begin
        err_cnt_inc  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
        err_sticky_d = mism | (err_sticky_q & ~bus.err_clr);
        err_cnt_d    = mism ? (bus.err_clr ? ERR_CNT_W'(1) : err_cnt_inc) :
                              (bus.err_clr ? '0 : err_cnt_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
    assign bus.parity_bit = parity_bit_q;
    assign bus.par_req    = par_req_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_parity_gen_chk.sv
// tb_parity_gen_chk: table-driven TX checks, directed RX corner cases and randomized frames vs a frame-level model.
module tb_parity_gen_chk;
    localparam int CNT_MAX = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    logic m_sticky = 1'b0;
    parity_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(2)) bus ();
    parity_gen_chk #(.WIDTH(8), .ERR_CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] mode;
        logic [7:0] data;
        logic       bit_e;
        logic       req_e;
    } tx_vec_t;
    tx_vec_t tv[8];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic ref_par(input logic [2:0] m, input logic [7:0] d);
        int ones;
        ones = $countones(d);
        case (m)
            3'd0:    return 1'b0;
            3'd2:    return (ones % 2) == 0;
            3'd3:    return 1'b1;
            3'd4:    return 1'b0;
            default: return (ones % 2) == 1;
        endcase
    endfunction
    task automatic chk_err();
        chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
        chk("err_cnt", 32'(bus.err_cnt), m_cnt);
    endtask
    task automatic tx_check(input logic [2:0] mode, input logic [7:0] data, input logic bit_e, input logic req_e);
        bus.PAR_MODE = mode;
        bus.P_DATA   = data;
        bus.tx_load  = 1'b1;
        step();
        bus.tx_load  = 1'b0;
        chk("tx_parity_bit", 32'(bus.parity_bit), 32'(bit_e));
        chk("tx_par_req", 32'(bus.par_req), 32'(req_e));
        bus.PAR_MODE = ~mode;
        bus.P_DATA   = ~data;
        step();
        chk("tx_hold_bit", 32'(bus.parity_bit), 32'(bit_e));
        chk("tx_hold_req", 32'(bus.par_req), 32'(req_e));
    endtask
    task automatic rx_abort(input int k);
        bus.PAR_MODE = 3'($urandom);
        bus.rx_start = 1'b1;
        step();
        bus.rx_start = 1'b0;
        for (int i = 0; i < k; i++) begin
            bus.rx_bit_vld = 1'b1;
            bus.rx_bit     = 1'($urandom);
            step();
            bus.rx_bit_vld = 1'b0;
            chk("abort_no_done", 32'(bus.rx_done), 0);
        end
    endtask
    task automatic rx_frame(input logic [2:0] mode, input logic [7:0] data, input logic par,
                            input logic clr, input bit gaps);
        logic exp_err;
        bus.PAR_MODE   = mode;
        bus.rx_start   = 1'b1;
        bus.rx_bit_vld = 1'($urandom);
        bus.rx_bit     = 1'($urandom);
        step();
        bus.rx_start   = 1'b0;
        bus.rx_bit_vld = 1'b0;
        bus.PAR_MODE   = 3'($urandom);
        chk("rx_done_start", 32'(bus.rx_done), 0);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) step();
            bus.rx_bit_vld = 1'b1;
            bus.rx_bit     = data[i];
            if (i == 7 && mode == 3'd0) bus.err_clr = clr;
            step();
            bus.rx_bit_vld = 1'b0;
            bus.err_clr    = 1'b0;
            if (i < 7 || mode != 3'd0) chk("rx_done_early", 32'(bus.rx_done), 0);
        end
        if (mode != 3'd0) begin
            if (gaps && $urandom_range(0, 1) == 0) step();
            bus.rx_bit_vld = 1'b1;
            bus.rx_bit     = par;
            bus.err_clr    = clr;
            step();
            bus.rx_bit_vld = 1'b0;
            bus.err_clr    = 1'b0;
        end
        exp_err = (mode != 3'd0) && (par != ref_par(mode, data));
        if (exp_err) begin
            m_sticky = 1'b1;
            m_cnt    = clr ? 1 : (m_cnt == CNT_MAX ? CNT_MAX : m_cnt + 1);
        end else if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end
        chk("rx_done", 32'(bus.rx_done), 1);
        chk("rx_par_err", 32'(bus.rx_par_err), 32'(exp_err));
        chk_err();
        step();
        chk("rx_done_pulse", 32'(bus.rx_done), 0);
    endtask
    initial begin
        bus.PAR_MODE = '0; bus.tx_load = 0; bus.P_DATA = '0; bus.rx_start = 0;
        bus.rx_bit_vld = 0; bus.rx_bit = 0; bus.err_clr = 0;
        tv[0] = '{3'd1, 8'hA5, 1'b0, 1'b1};
        tv[1] = '{3'd2, 8'hA5, 1'b1, 1'b1};
        tv[2] = '{3'd0, 8'h01, 1'b0, 1'b0};
        tv[3] = '{3'd3, 8'h00, 1'b1, 1'b1};
        tv[4] = '{3'd4, 8'hFF, 1'b0, 1'b1};
        tv[5] = '{3'd1, 8'h01, 1'b1, 1'b1};
        tv[6] = '{3'd5, 8'h01, 1'b1, 1'b1};
        tv[7] = '{3'd7, 8'h03, 1'b0, 1'b1};
        step();
        step();
        chk("rst_parity_bit", 32'(bus.parity_bit), 0);
        chk("rst_par_req", 32'(bus.par_req), 0);
        chk("rst_rx_done", 32'(bus.rx_done), 0);
        chk("rst_rx_par_err", 32'(bus.rx_par_err), 0);
        chk_err();
        rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) tx_check(tv[i].mode, tv[i].data, tv[i].bit_e, tv[i].req_e);
        // Directed RX: good even frame, then the same frame with a bad parity bit.
        rx_frame(3'd1, 8'hA5, 1'b0, 1'b0, 0);
        rx_frame(3'd1, 8'hA5, 1'b1, 1'b0, 0);
        rx_frame(3'd0, 8'h5A, 1'b0, 1'b0, 0);
        rx_abort(3);
        rx_frame(3'd1, 8'hA5, 1'b0, 1'b0, 0);
        bus.rx_bit_vld = 1'b1;
        step();
        bus.rx_bit_vld = 1'b0;
        chk("idle_vld_ignored", 32'(bus.rx_done), 0);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        m_cnt = 0;
        m_sticky = 1'b0;
        chk_err();
        for (int i = 0; i < 5; i++) rx_frame(3'd2, 8'hA5, 1'b0, 1'b0, 0);
        rx_frame(3'd2, 8'hA5, 1'b0, 1'b1, 0);
        // Reset while waiting for the parity bit.
        tx_check(3'd3, 8'h12, 1'b1, 1'b1);
        bus.PAR_MODE = 3'd1;
        bus.rx_start = 1'b1;
        step();
        bus.rx_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rx_bit_vld = 1'b1;
            bus.rx_bit     = 1'($urandom);
            step();
        end
        bus.rx_bit_vld = 1'b0;
        rst = 1'b1;
        #1;
        m_cnt = 0;
        m_sticky = 1'b0;
        chk("mid_rst_parity_bit", 32'(bus.parity_bit), 0);
        chk("mid_rst_par_req", 32'(bus.par_req), 0);
        chk_err();
        #1 rst = 1'b0;
        bus.rx_bit_vld = 1'b1;
        bus.rx_bit     = 1'b1;
        step();
        bus.rx_bit_vld = 1'b0;
        chk("post_rst_no_done", 32'(bus.rx_done), 0);
        chk_err();
        rx_frame(3'd2, 8'h3C, 1'b1, 1'b0, 0);
        rx_frame(3'd2, 8'h3C, 1'b0, 1'b0, 0);
        // Randomized frames and TX loads against the model.
        for (int n = 0; n < 200; n++) begin
            logic [2:0] m;
            logic [7:0] d;
            m = 3'($urandom);
            d = 8'($urandom);
            tx_check(m, d, ref_par(m, d), m != 3'd0);
            if ($urandom_range(0, 5) == 0) rx_abort($urandom_range(0, 7));
            rx_frame(3'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
